inst_rom_arbiter: RTL and testbench

Shares the single combinational instruction ROM port between two requesters.
- Master 0: the CPU fetch path.
- Master 1: a debug/loader read path.

It arbitrates one access per cycle, drives the ROM chip-enable and address, and registers the returned word. Each master sees a fixed 1-cycle read latency with a req/gnt/rvalid handshake. Misaligned or out-of-range addresses are flagged without touching the ROM.

---
 rtl/inst_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_inst_rom_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_arbiter
// Description : Shares one combinational instruction ROM port between the CPU
//               fetch path (m0) and a debug/loader read path (m1). It accepts
//               one access per cycle and returns the word with a fixed
//               1-cycle latency. Misaligned or out-of-range addresses are
//               flagged as errors and the ROM is not enabled for them.
// Ports       : clk, rst_n           - clock, async active-low reset
//               m0_req/addr/flush    - fetch request, byte address, flush
//               m0_gnt/rvalid/rdata/err - fetch grant and response
//               m1_req/addr          - debug request, byte address
//               m1_gnt/rvalid/rdata/err - debug grant and response
//               rom_ce/addr/inst     - ROM port (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH_LOG2   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_flush,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam int                 c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    // Owner of the response due in the current cycle.
    localparam logic [1:0] c_PEND_NONE = 2'd0;
    localparam logic [1:0] c_PEND_M0   = 2'd1;
    localparam logic [1:0] c_PEND_M1   = 2'd2;

    logic [1:0]         r_pend;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [DATA_W-1:0]  r_m0_rdata;
    logic [DATA_W-1:0]  r_m1_rdata;
    logic               r_m0_err;
    logic               r_m1_err;

    logic               w_m1_win;
    logic               w_gnt0;
    logic               w_gnt1;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_err;
    logic [DATA_W-1:0]  w_rdata;

    always_comb begin
        // m0 has priority unless m1 is alone or has waited long enough.
        // Grants are held off while reset is asserted.
        w_m1_win = rst_n && m1_req && (!m0_req || (r_starve_cnt == c_STARVE_MAX));
        w_gnt0   = rst_n && m0_req && !w_m1_win;
        w_gnt1   = w_m1_win;
        w_addr   = w_gnt1 ? m1_addr : m0_addr;
        w_err    = (w_addr[1:0] != 2'b00) ||
                   (w_addr[ADDR_W-1:DEPTH_LOG2+2] != '0);
        rom_ce   = (w_gnt0 || w_gnt1) && !w_err;
        rom_addr = rom_ce ? w_addr : '0;
        // Erroring accesses never see ROM data, so the response is zero.
        w_rdata  = w_err ? '0 : rom_inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= c_PEND_NONE;
            r_starve_cnt <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_pend     <= c_PEND_M0;
                r_m0_rdata <= w_rdata;
                r_m0_err   <= w_err;
            end else if (w_gnt1) begin
                r_pend     <= c_PEND_M1;
                r_m1_rdata <= w_rdata;
                r_m1_err   <= w_err;
            end else begin
                r_pend     <= c_PEND_NONE;
            end

            if (m1_req && !w_gnt1) begin
                if (r_starve_cnt != c_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    // A branch redirect suppresses the fetch response landing this cycle.
    assign m0_rvalid = (r_pend == c_PEND_M0) && !m0_flush;
    assign m1_rvalid = (r_pend == c_PEND_M1);
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_err    = r_m0_err;
    assign m1_err    = r_m1_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rom_arbiter
// Description : Self-checking bench for inst_rom_arbiter. A ROM array drives
//               rom_inst; a behavioural model predicts every output each
//               cycle; directed sequences pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_arbiter;

    localparam int c_AW    = 32;
    localparam int c_DW    = 32;
    localparam int c_LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            m0_req, m0_flush, m1_req;
    logic [c_AW-1:0] m0_addr, m1_addr;
    logic            m0_gnt, m0_rvalid, m0_err;
    logic            m1_gnt, m1_rvalid, m1_err;
    logic [c_DW-1:0] m0_rdata, m1_rdata;
    logic            rom_ce;
    logic [c_AW-1:0] rom_addr;
    logic [c_DW-1:0] rom_inst;

    logic [c_DW-1:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Undriven ROM output is poisoned so stray captures are visible.
    assign rom_inst = rom_ce ? mem[rom_addr[9:2]] : 32'hDEAD_BEEF;

    inst_rom_arbiter #(
        .ADDR_W(c_AW), .DATA_W(c_DW), .DEPTH_LOG2(8), .STARVE_LIMIT(c_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_flush(m0_flush),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              md_wait;          // consecutive denied m1 cycles
    bit              md_due0, md_due1; // response owed this cycle
    logic [c_DW-1:0] md_d0, md_d1;
    bit              md_e0, md_e1;

    always @(negedge clk) begin
        bit              m1_wins, g0, g1, bad, ce;
        logic [c_AW-1:0] a;
        if (!rst_n) begin
            chk("rst_m0_gnt", 64'(m0_gnt), 0);
            chk("rst_m1_gnt", 64'(m1_gnt), 0);
            chk("rst_rom_ce", 64'(rom_ce), 0);
            chk("rst_m0_rvalid", 64'(m0_rvalid), 0);
            chk("rst_m1_rvalid", 64'(m1_rvalid), 0);
            chk("rst_m0_rdata", 64'(m0_rdata), 0);
            chk("rst_m1_rdata", 64'(m1_rdata), 0);
            chk("rst_m0_err", 64'(m0_err), 0);
            chk("rst_m1_err", 64'(m1_err), 0);
            md_wait = 0; md_due0 = 0; md_due1 = 0;
            md_d0 = '0; md_d1 = '0; md_e0 = 0; md_e1 = 0;
        end else begin
            m1_wins = m1_req && (!m0_req || md_wait >= c_LIMIT);
            g0      = m0_req && !m1_wins;
            g1      = m1_wins;
            a       = g1 ? m1_addr : m0_addr;
            bad     = (a % 4 != 0) || (a >= 32'd1024);
            ce      = (g0 || g1) && !bad;
            chk("m0_gnt", 64'(m0_gnt), 64'(g0));
            chk("m1_gnt", 64'(m1_gnt), 64'(g1));
            chk("rom_ce", 64'(rom_ce), 64'(ce));
            chk("rom_addr", 64'(rom_addr), ce ? 64'(a) : 64'd0);
            chk("m0_rvalid", 64'(m0_rvalid), 64'(md_due0 && !m0_flush));
            chk("m1_rvalid", 64'(m1_rvalid), 64'(md_due1));
            chk("m0_rdata", 64'(m0_rdata), 64'(md_d0));
            chk("m1_rdata", 64'(m1_rdata), 64'(md_d1));
            chk("m0_err", 64'(m0_err), 64'(md_e0));
            chk("m1_err", 64'(m1_err), 64'(md_e1));
            // State as it will be after the coming rising edge.
            md_due0 = g0;
            md_due1 = g1;
            if (g0) begin md_d0 = bad ? '0 : mem[a / 4]; md_e0 = bad; end
            if (g1) begin md_d1 = bad ? '0 : mem[a / 4]; md_e1 = bad; end
            if (m1_req && !g1) md_wait = (md_wait + 1 > c_LIMIT) ? c_LIMIT : md_wait + 1;
            else               md_wait = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [c_AW-1:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0)      return {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        else if (r == 1) return ($urandom | 32'h400) & 32'hFFFF_FFFC;
        else             return {22'd0, 8'($urandom), 2'b00};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[2] = 32'h0050_0093;
        mem[3] = 32'h00A0_0113;
        mem[5] = 32'h1234_5678;
        rst_n = 1'b0; m0_req = 0; m1_req = 0; m0_flush = 0;
        m0_addr = '0; m1_addr = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Single fetch from word 2.
        m0_req = 1; m0_addr = 32'h8;
        @(negedge clk);
        chk("d1_gnt", 64'(m0_gnt), 1);
        chk("d1_ce", 64'(rom_ce), 1);
        chk("d1_addr", 64'(rom_addr), 64'h8);
        cyc(); m0_req = 0;
        @(negedge clk);
        chk("d1_rvalid", 64'(m0_rvalid), 1);
        chk("d1_rdata", 64'(m0_rdata), 64'h0050_0093);
        chk("d1_err", 64'(m0_err), 0);
        cyc();

        // Both request: four m0 grants then one m1 grant, repeating.
        m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h14;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("d2_m1_gnt", 64'(m1_gnt), 64'(k % 5 == 4));
            chk("d2_m0_gnt", 64'(m0_gnt), 64'(k % 5 != 4));
            if (k > 0) chk("d2_m1_rvalid", 64'(m1_rvalid), 64'((k - 1) % 5 == 4));
            if (k == 5) chk("d2_m1_rdata", 64'(m1_rdata), 64'h1234_5678);
            cyc();
        end
        m0_req = 0; m1_req = 0;
        cyc();

        // Misaligned, then out-of-range debug reads.
        m1_req = 1; m1_addr = 32'h6;
        @(negedge clk);
        chk("d3_gnt", 64'(m1_gnt), 1);
        chk("d3_ce", 64'(rom_ce), 0);
        cyc(); m1_addr = 32'h400;
        @(negedge clk);
        chk("d3_rvalid_a", 64'(m1_rvalid), 1);
        chk("d3_err_a", 64'(m1_err), 1);
        chk("d3_rdata_a", 64'(m1_rdata), 0);
        chk("d3_ce_b", 64'(rom_ce), 0);
        cyc(); m1_req = 0;
        @(negedge clk);
        chk("d3_rvalid_b", 64'(m1_rvalid), 1);
        chk("d3_err_b", 64'(m1_err), 1);
        chk("d3_rdata_b", 64'(m1_rdata), 0);
        cyc();

        // Flush drops the due response but not a new grant.
        m0_req = 1; m0_addr = 32'h8;
        cyc(); m0_addr = 32'hC; m0_flush = 1;
        @(negedge clk);
        chk("d4_flushed", 64'(m0_rvalid), 0);
        chk("d4_gnt", 64'(m0_gnt), 1);
        cyc(); m0_req = 0; m0_flush = 0;
        @(negedge clk);
        chk("d4_rvalid", 64'(m0_rvalid), 1);
        chk("d4_rdata", 64'(m0_rdata), 64'h00A0_0113);
        cyc();

        // Reset right after a grant discards the response.
        m0_req = 1; m0_addr = 32'h8;
        cyc(); rst_n = 0;
        @(negedge clk);
        chk("d5_rvalid", 64'(m0_rvalid), 0);
        chk("d5_rdata", 64'(m0_rdata), 0);
        chk("d5_ce", 64'(rom_ce), 0);
        cyc(); rst_n = 1; m0_req = 0;
        @(negedge clk);
        chk("d5_rvalid_after", 64'(m0_rvalid), 0);
        chk("d5_rdata_after", 64'(m0_rdata), 0);
        cyc();

        // Randomised traffic; the model process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) rst_n = 0;
            else rst_n = 1;
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 2) == 0);
            m0_flush = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) != 0) m0_addr = rand_addr();
            if ($urandom_range(0, 2) != 0) m1_addr = rand_addr();
            cyc();
        end
        rst_n = 1; m0_req = 0; m1_req = 0; m0_flush = 0;
        repeat (2) cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
